// File: rtl/manchester_decoder.sv
// Manchester line decoder. Oversamples rx on clk16x, locks onto the
// 3H-high / 3H-low sync preamble, then decodes LSB-first Manchester bytes,
// re-centring its bit timer on every mid-bit transition.
module manchester_decoder #(
   parameter int HALF_BIT_LEN = 40,
   parameter int TOL          = 8
) (
   input  logic       clk16x,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_active,
   output logic       frame_end,
   output logic       decode_error
);

   // Timing landmarks, all expressed in the 16-bit counter domain.
   localparam logic [15:0] HALF     = 16'(HALF_BIT_LEN);
   localparam logic [15:0] SYNC_MIN = 16'(3 * HALF_BIT_LEN - TOL);
   localparam logic [15:0] SYNC_MAX = 16'(3 * HALF_BIT_LEN + TOL);
   localparam logic [15:0] SYNC_END = 16'(3 * HALF_BIT_LEN - 1);
   localparam logic [15:0] MID_MIN  = 16'(HALF_BIT_LEN - TOL);
   localparam logic [15:0] MID_MAX  = 16'(HALF_BIT_LEN + TOL);
   localparam logic [15:0] S1_AT    = 16'(HALF_BIT_LEN / 2);
   localparam logic [15:0] S2_AT    = 16'(HALF_BIT_LEN + HALF_BIT_LEN / 2);
   localparam logic [15:0] BIT_END  = 16'(2 * HALF_BIT_LEN - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SYNC_HIGH = 2'd1,
      SYNC_LOW  = 2'd2,
      DATA      = 2'd3
   } state_t;

   state_t      state, state_next;
   logic        rx_meta, rs, rs_d;
   logic [15:0] cnt, cnt_next;
   logic [2:0]  idx, idx_next;
   logic [7:0]  shreg, shreg_next;
   logic        s1, s1_next, s2, s2_next;
   logic [7:0]  data_out_next;
   logic        dv_next, fe_next, err_next;
   logic        rise, fall;

   assign rise = rs & ~rs_d;
   assign fall = ~rs & rs_d;

   // Input synchronizer plus the delay flop used for edge detection.
   always_ff @(posedge clk16x) begin
      if (reset) begin
         rx_meta <= 1'b0;
         rs      <= 1'b0;
         rs_d    <= 1'b0;
      end else begin
         rx_meta <= rx;
         rs      <= rx_meta;
         rs_d    <= rs;
      end
   end

   // State, counters, datapath and registered outputs.
   always_ff @(posedge clk16x) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= 16'd0;
         idx          <= 3'd0;
         shreg        <= 8'd0;
         s1           <= 1'b0;
         s2           <= 1'b0;
         data_out     <= 8'd0;
         data_valid   <= 1'b0;
         frame_end    <= 1'b0;
         decode_error <= 1'b0;
         frame_active <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         idx          <= idx_next;
         shreg        <= shreg_next;
         s1           <= s1_next;
         s2           <= s2_next;
         data_out     <= data_out_next;
         data_valid   <= dv_next;
         frame_end    <= fe_next;
         decode_error <= err_next;
         frame_active <= (state_next == DATA);
      end
   end

   // Next-state logic: sync qualification, bit sampling, resync and bit evaluation.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      idx_next      = idx;
      shreg_next    = shreg;
      s1_next       = s1;
      s2_next       = s2;
      data_out_next = data_out;
      dv_next       = 1'b0;
      fe_next       = 1'b0;
      err_next      = 1'b0;

      case (state)
         IDLE: begin
            if (rise) begin
               state_next = SYNC_HIGH;
               cnt_next   = 16'd0;
            end else begin
               cnt_next = 16'd0;
            end
         end

         SYNC_HIGH: begin
            if (fall) begin
               if ((cnt >= SYNC_MIN) && (cnt <= SYNC_MAX)) begin
                  state_next = SYNC_LOW;
                  cnt_next   = 16'd0;
               end else begin
                  // Wrong-length pulse: treated as noise, not an error.
                  state_next = IDLE;
               end
            end else if (cnt > SYNC_MAX) begin
               // Stuck-high line; only a fresh rise can restart the search.
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 16'd1;
            end
         end

         SYNC_LOW: begin
            if (rise && (cnt < SYNC_MIN)) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else if (cnt == SYNC_END) begin
               // A rise landing here is the first half of a 0 bit.
               state_next = DATA;
               cnt_next   = 16'd0;
               idx_next   = 3'd0;
               shreg_next = 8'd0;
            end else begin
               cnt_next = cnt + 16'd1;
            end
         end

         DATA: begin
            cnt_next = cnt + 16'd1;
            if (cnt == S1_AT) begin
               s1_next = rs;
            end else begin
               s1_next = s1;
            end
            if (cnt == S2_AT) begin
               s2_next = rs;
            end else begin
               s2_next = s2;
            end

            if (cnt == BIT_END) begin
               if (s1 != s2) begin
                  shreg_next[idx] = s2;
                  cnt_next        = 16'd0;
                  if (idx == 3'd7) begin
                     data_out_next = {s2, shreg[6:0]};
                     dv_next       = 1'b1;
                     idx_next      = 3'd0;
                  end else begin
                     idx_next = idx + 3'd1;
                  end
               end else if (!s1 && (idx == 3'd0)) begin
                  // Line idle-low on a byte boundary: clean end of frame.
                  fe_next    = 1'b1;
                  state_next = IDLE;
               end else begin
                  err_next   = 1'b1;
                  shreg_next = 8'd0;
                  state_next = IDLE;
               end
            end else if ((rise || fall) && (cnt >= MID_MIN) && (cnt <= MID_MAX)) begin
               // Mid-bit transition re-centres the bit timer.
               cnt_next = HALF;
            end else begin
               cnt_next = cnt + 16'd1;
            end
         end

         default: begin
            state_next = IDLE;
            cnt_next   = 16'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_manchester_decoder.sv
// Directed testbench for manchester_decoder: drives Manchester frames on rx
// and checks decoded bytes, pulse timing, framing errors and reset abort.
module tb_manchester_decoder;

   localparam int H = 40;

   logic       clk16x = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_active;
   logic       frame_end;
   logic       decode_error;

   int passed = 0;
   int total  = 0;

   manchester_decoder #(.HALF_BIT_LEN(H), .TOL(8)) dut (
      .clk16x      (clk16x),
      .reset       (reset),
      .rx          (rx),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_active(frame_active),
      .frame_end   (frame_end),
      .decode_error(decode_error)
   );

   // 10-unit clock period.
   always #5 clk16x = ~clk16x;

   int cyc = 0;
   // Free-running cycle stamp.
   always @(posedge clk16x) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge.
   int         dv_total = 0, fe_total = 0, err_total = 0, both_total = 0;
   int         fe_cyc = 0, err_cyc = 0;
   int         fa_hold = 0, fa_drop = 0;
   bit         fa_watch = 1'b0;
   logic [7:0] dv_data[$];
   int         dv_cyc[$];

   always @(negedge clk16x) begin
      if (data_valid) begin
         dv_total++;
         dv_data.push_back(data_out);
         dv_cyc.push_back(cyc);
      end
      if (frame_end) begin
         fe_total++;
         fe_cyc = cyc;
      end
      if (decode_error) begin
         err_total++;
         err_cyc = cyc;
      end
      if (data_valid && frame_end) both_total++;
      if (!fa_watch) fa_hold = 0;
      else if (fa_hold < 8) fa_hold++;
      else if (!frame_active) fa_drop++;
   end

   task automatic line(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk16x);
   endtask

   task automatic send_sync();
      line(1'b1, 3 * H);
      line(1'b0, 3 * H);
   endtask

   task automatic send_byte(input logic [7:0] d);
      for (int i = 0; i < 8; i++) begin
         line(~d[i], H);
         line(d[i], H);
      end
   endtask

   task automatic test_reset();
      total++; if (data_out !== 8'h00) $display("FAIL reset_data_out got %h exp %h", data_out, 8'h00); else passed++;
      total++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid got %b exp 0", data_valid); else passed++;
      total++; if (frame_active !== 1'b0) $display("FAIL reset_frame_active got %b exp 0", frame_active); else passed++;
      total++; if (frame_end !== 1'b0) $display("FAIL reset_frame_end got %b exp 0", frame_end); else passed++;
      total++; if (decode_error !== 1'b0) $display("FAIL reset_decode_error got %b exp 0", decode_error); else passed++;
      reset = 1'b0;
      line(1'b0, 20);
   endtask

   task automatic test_single();
      int dv0, fe0, err0, end_cyc, lat, gap;
      dv0 = dv_total; fe0 = fe_total; err0 = err_total;
      send_sync();
      send_byte(8'hA5);
      end_cyc = cyc;
      line(1'b0, 300);
      total++; if (dv_total - dv0 !== 1) $display("FAIL single_dv_count got %0d exp 1", dv_total - dv0); else passed++;
      total++; if (dv_data.size() < 1 || dv_data[dv_data.size()-1] !== 8'hA5)
         $display("FAIL single_data got %h exp a5", (dv_data.size() > 0) ? dv_data[dv_data.size()-1] : 8'hxx); else passed++;
      total++; if (fe_total - fe0 !== 1) $display("FAIL single_fe_count got %0d exp 1", fe_total - fe0); else passed++;
      total++; if (err_total - err0 !== 0) $display("FAIL single_err_count got %0d exp 0", err_total - err0); else passed++;
      lat = (dv_cyc.size() > 0) ? dv_cyc[dv_cyc.size()-1] - end_cyc : -1;
      // Two synchronizer stages plus the output register.
      total++; if (lat < 2 || lat > 4) $display("FAIL single_dv_latency got %0d exp 2..4", lat); else passed++;
      gap = (dv_cyc.size() > 0) ? fe_cyc - dv_cyc[dv_cyc.size()-1] : -1;
      // The idle-low bit after the byte is evaluated one bit period later.
      total++; if (gap !== 2 * H) $display("FAIL single_fe_gap got %0d exp %0d", gap, 2 * H); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [3];
      int dv0, fe0, err0, base, drop0, sp;
      exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
      dv0 = dv_total; fe0 = fe_total; err0 = err_total; base = dv_data.size(); drop0 = fa_drop;
      send_sync();
      fa_watch = 1'b1;
      for (int b = 0; b < 3; b++) send_byte(exp_b[b]);
      fa_watch = 1'b0;
      line(1'b0, 300);
      total++; if (dv_total - dv0 !== 3) $display("FAIL b2b_dv_count got %0d exp 3", dv_total - dv0); else passed++;
      for (int b = 0; b < 3; b++) begin
         total++;
         if (dv_data.size() < base + b + 1 || dv_data[base+b] !== exp_b[b])
            $display("FAIL b2b_data%0d got %h exp %h", b, (dv_data.size() > base + b) ? dv_data[base+b] : 8'hxx, exp_b[b]);
         else passed++;
      end
      for (int b = 0; b < 2; b++) begin
         sp = (dv_cyc.size() > base + b + 1) ? dv_cyc[base+b+1] - dv_cyc[base+b] : -1;
         // Eight bit periods of 2H cycles each.
         total++; if (sp !== 16 * H) $display("FAIL b2b_spacing%0d got %0d exp %0d", b, sp, 16 * H); else passed++;
      end
      total++; if (fe_total - fe0 !== 1) $display("FAIL b2b_fe_count got %0d exp 1", fe_total - fe0); else passed++;
      total++; if (err_total - err0 !== 0) $display("FAIL b2b_err_count got %0d exp 0", err_total - err0); else passed++;
      total++; if (fa_drop - drop0 !== 0) $display("FAIL b2b_frame_active_drops got %0d exp 0", fa_drop - drop0); else passed++;
   endtask

   task automatic test_bad_sync();
      int ev0, dv0, err0;
      // High pulse far too short.
      ev0 = dv_total + fe_total + err_total;
      line(1'b1, 60);
      line(1'b0, 300);
      total++; if (dv_total + fe_total + err_total - ev0 !== 0)
         $display("FAIL badsync_short_events got %0d exp 0", dv_total + fe_total + err_total - ev0); else passed++;
      // High pulse too long: timeout in SYNC_HIGH.
      ev0 = dv_total + fe_total + err_total;
      line(1'b1, 200);
      line(1'b0, 300);
      total++; if (dv_total + fe_total + err_total - ev0 !== 0)
         $display("FAIL badsync_long_events got %0d exp 0", dv_total + fe_total + err_total - ev0); else passed++;
      total++; if (frame_active !== 1'b0) $display("FAIL badsync_long_active got %b exp 0", frame_active); else passed++;
      // Valid high, then premature rise in the low phase.
      dv0 = dv_total; err0 = err_total;
      line(1'b1, 3 * H);
      line(1'b0, 40);
      line(1'b1, 40);
      line(1'b0, 300);
      total++; if (err_total - err0 !== 1) $display("FAIL badsync_early_rise_err got %0d exp 1", err_total - err0); else passed++;
      total++; if (dv_total - dv0 !== 0) $display("FAIL badsync_early_rise_dv got %0d exp 0", dv_total - dv0); else passed++;
   endtask

   task automatic test_violation();
      logic [7:0] d;
      int dv0, fe0, err0, end_cyc, lat;
      d = 8'h5A;
      dv0 = dv_total; fe0 = fe_total; err0 = err_total;
      send_sync();
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            line(1'b1, 2 * H);
            end_cyc = cyc;
         end else begin
            line(~d[i], H);
            line(d[i], H);
         end
      end
      line(1'b0, 300);
      total++; if (err_total - err0 !== 1) $display("FAIL viol_err_count got %0d exp 1", err_total - err0); else passed++;
      total++; if (dv_total - dv0 !== 0) $display("FAIL viol_dv_count got %0d exp 0", dv_total - dv0); else passed++;
      total++; if (fe_total - fe0 !== 0) $display("FAIL viol_fe_count got %0d exp 0", fe_total - fe0); else passed++;
      lat = err_cyc - end_cyc;
      total++; if (lat < 2 || lat > 4) $display("FAIL viol_err_latency got %0d exp 2..4", lat); else passed++;
      total++; if (frame_active !== 1'b0) $display("FAIL viol_idle_after got %b exp 0", frame_active); else passed++;
      // Clean recovery frame.
      dv0 = dv_total; fe0 = fe_total; err0 = err_total;
      send_sync();
      send_byte(8'h11);
      line(1'b0, 300);
      total++; if (dv_total - dv0 !== 1) $display("FAIL viol_recover_dv got %0d exp 1", dv_total - dv0); else passed++;
      total++; if (dv_data.size() < 1 || dv_data[dv_data.size()-1] !== 8'h11)
         $display("FAIL viol_recover_data got %h exp 11", (dv_data.size() > 0) ? dv_data[dv_data.size()-1] : 8'hxx); else passed++;
      total++; if (err_total - err0 !== 0) $display("FAIL viol_recover_err got %0d exp 0", err_total - err0); else passed++;
      total++; if (fe_total - fe0 !== 1) $display("FAIL viol_recover_fe got %0d exp 1", fe_total - fe0); else passed++;
   endtask

   task automatic test_jitter();
      logic [7:0] d;
      int dv0, fe0, err0;
      d = 8'hC3;
      dv0 = dv_total; fe0 = fe_total; err0 = err_total;
      send_sync();
      for (int i = 0; i < 8; i++) begin
         line(~d[i], int'($urandom_range(44, 36)));
         line(d[i], int'($urandom_range(44, 36)));
      end
      line(1'b0, 300);
      total++; if (dv_total - dv0 !== 1) $display("FAIL jitter_dv_count got %0d exp 1", dv_total - dv0); else passed++;
      total++; if (dv_data.size() < 1 || dv_data[dv_data.size()-1] !== 8'hC3)
         $display("FAIL jitter_data got %h exp c3", (dv_data.size() > 0) ? dv_data[dv_data.size()-1] : 8'hxx); else passed++;
      total++; if (err_total - err0 !== 0) $display("FAIL jitter_err got %0d exp 0", err_total - err0); else passed++;
      total++; if (fe_total - fe0 !== 1) $display("FAIL jitter_fe got %0d exp 1", fe_total - fe0); else passed++;
   endtask

   task automatic test_mid_reset();
      logic [7:0] d;
      int ev0, dv0, fe0, err0;
      d = 8'h7E;
      ev0 = dv_total + fe_total + err_total;
      send_sync();
      for (int i = 0; i < 3; i++) begin
         line(~d[i], H);
         line(d[i], H);
      end
      line(1'b0, 20);
      reset = 1'b1;
      @(negedge clk16x);
      total++; if (frame_active !== 1'b0) $display("FAIL midrst_frame_active got %b exp 0", frame_active); else passed++;
      total++; if (data_out !== 8'h00) $display("FAIL midrst_data_out got %h exp 00", data_out); else passed++;
      total++; if (data_valid !== 1'b0) $display("FAIL midrst_data_valid got %b exp 0", data_valid); else passed++;
      total++; if (frame_end !== 1'b0) $display("FAIL midrst_frame_end got %b exp 0", frame_end); else passed++;
      total++; if (decode_error !== 1'b0) $display("FAIL midrst_decode_error got %b exp 0", decode_error); else passed++;
      reset = 1'b0;
      line(1'b0, 300);
      total++; if (dv_total + fe_total + err_total - ev0 !== 0)
         $display("FAIL midrst_aborted_events got %0d exp 0", dv_total + fe_total + err_total - ev0); else passed++;
      dv0 = dv_total; fe0 = fe_total; err0 = err_total;
      send_sync();
      send_byte(8'h7E);
      line(1'b0, 300);
      total++; if (dv_total - dv0 !== 1) $display("FAIL midrst_next_dv got %0d exp 1", dv_total - dv0); else passed++;
      total++; if (dv_data.size() < 1 || dv_data[dv_data.size()-1] !== 8'h7E)
         $display("FAIL midrst_next_data got %h exp 7e", (dv_data.size() > 0) ? dv_data[dv_data.size()-1] : 8'hxx); else passed++;
      total++; if (fe_total - fe0 !== 1) $display("FAIL midrst_next_fe got %0d exp 1", fe_total - fe0); else passed++;
      total++; if (err_total - err0 !== 0) $display("FAIL midrst_next_err got %0d exp 0", err_total - err0); else passed++;
   endtask

   task automatic test_exclusive();
      total++; if (both_total !== 0) $display("FAIL dv_fe_overlap got %0d exp 0", both_total); else passed++;
   endtask

   initial begin
      reset = 1'b1;
      rx    = 1'b0;
      repeat (3) @(negedge clk16x);
      test_reset();
      test_single();
      test_back_to_back();
      test_bad_sync();
      test_violation();
      test_jitter();
      test_mid_reset();
      test_exclusive();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
